// File: rtl/multi_chan_cov_dut.sv
// Multi-channel stimulus core: per-channel counter, conditional accumulator and phase FSM,
// with samples drained through a single round-robin valid/ready stream.
//
// phase | meaning
// 0..PHASE_MAX-1 | advance by one on every second enabled cycle (tog=1)
// PHASE_MAX      | wraps to 0 on the next advance
module multi_chan_cov_dut #(
  parameter int CH        = 4,
  parameter int W         = 8,
  parameter int PHASE_MAX = 5,
  parameter int PW        = 4,
  parameter int THRESH    = 10,
  parameter int ACC_SAT   = 0,
  localparam int CHW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CH-1:0]     en_i,
  input  logic [CH-1:0]     clr_i,
  output logic [CH-1:0]     above_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHW-1:0]    out_ch,
  output logic [W-1:0]      out_value,
  output logic [63:0]       out_value64,
  output logic [PW-1:0]     out_phase
);

  logic [W-1:0]   cnt_q   [CH];
  logic [W-1:0]   cnt_d   [CH];
  logic [W-1:0]   acc_q   [CH];
  logic [W-1:0]   acc_d   [CH];
  logic [PW-1:0]  phase_q [CH];
  logic [PW-1:0]  phase_d [CH];
  logic [CH-1:0]  tog_q, tog_d;
  logic [CHW-1:0] rr_q, rr_d;
  logic           load;

  // Increment/decrement decisions use the counter value before this edge's update.
  function automatic logic [W-1:0] acc_next(input logic [W-1:0] a, input logic [W-1:0] c);
    logic [W-1:0] r;
    r = a;
    if (c[0] & c[1]) begin
      if (!((ACC_SAT != 0) && (a == '1))) r = a + W'(1);
    end else if (c[2] | c[3]) begin
      if (!((ACC_SAT != 0) && (a == '0))) r = a - W'(1);
    end
    return r;
  endfunction

  assign load = !out_valid || out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        cnt_q[c]   <= '0;
        acc_q[c]   <= '0;
        phase_q[c] <= '0;
      end
      tog_q       <= '0;
      rr_q        <= '0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_value   <= '0;
      out_value64 <= '0;
      out_phase   <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        cnt_q[c]   <= cnt_d[c];
        acc_q[c]   <= acc_d[c];
        phase_q[c] <= phase_d[c];
      end
      tog_q <= tog_d;
      rr_q  <= rr_d;
      if (load) begin
        out_valid   <= 1'b1;
        out_ch      <= rr_q;
        out_value   <= acc_q[rr_q] + cnt_q[rr_q];
        out_value64 <= 64'(cnt_q[rr_q]);
        out_phase   <= phase_q[rr_q];
      end
    end
  end

  always_comb begin
    tog_d = tog_q;
    for (int c = 0; c < CH; c++) begin
      cnt_d[c]   = cnt_q[c];
      acc_d[c]   = acc_q[c];
      phase_d[c] = phase_q[c];
      if (clr_i[c]) begin
        cnt_d[c]   = '0;
        acc_d[c]   = '0;
        phase_d[c] = '0;
        tog_d[c]   = 1'b0;
      end else if (en_i[c]) begin
        cnt_d[c] = cnt_q[c] + W'(1);
        acc_d[c] = acc_next(acc_q[c], cnt_q[c]);
        tog_d[c] = ~tog_q[c];
        if (tog_q[c]) begin
          phase_d[c] = (phase_q[c] == PW'(PHASE_MAX)) ? '0 : phase_q[c] + PW'(1);
        end
      end
    end
    rr_d = rr_q;
    if (load) begin
      rr_d = (rr_q == CHW'(CH - 1)) ? '0 : rr_q + CHW'(1);
    end
  end

  always_comb begin
    above_o = '0;
    for (int c = 0; c < CH; c++) begin
      above_o[c] = int'(cnt_q[c]) > THRESH;
    end
  end

endmodule
